// File: rtl/ad_buf_frame_ctrl.sv
// ad_buf_frame_ctrl
//   Read-side controller for the AD sample async FIFO in the HSST transmit
//   path. Drains the FIFO in bursts, packs bytes into 32-bit words and wraps
//   each burst as SOF word, payload words, then an EOF word that carries the
//   received byte count and the XOR checksum.
//
// Ports
//   rd_clk, rd_rst      FIFO read clock; synchronous active-high reset
//   enable              frames may start (looked at in IDLE only)
//   fifo_rd_en          FIFO read enable
//   fifo_rd_data        FIFO data, valid FIFO_RD_LAT cycles after fifo_rd_en
//   fifo_rd_empty       FIFO empty
//   fifo_almost_empty   FIFO holds 4 entries or fewer
//   tx_valid/tx_ready   output word stream to the TX lane wrapper
//   tx_data, tx_kchar   output word; byte0 = [7:0] is the oldest byte
//   frame_busy          high from SOF load until EOF accepted
//   frame_seq           sequence number of the current/next frame
//   fsm_state           debug view of the controller state
//
// Handshake: a word is transferred on every rising edge where tx_valid and
// tx_ready are both high. While tx_valid is high and tx_ready low, tx_data
// and tx_kchar hold steady. A new word may load in the same cycle the
// previous one is accepted.
module ad_buf_frame_ctrl #(
  parameter int MAX_FRAME_BYTES = 256,
  parameter int IDLE_TIMEOUT    = 64,
  parameter int FIFO_RD_LAT     = 1
) (
  input  logic        rd_clk,
  input  logic        rd_rst,
  input  logic        enable,
  output logic        fifo_rd_en,
  input  logic [7:0]  fifo_rd_data,
  input  logic        fifo_rd_empty,
  input  logic        fifo_almost_empty,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] tx_data,
  output logic [3:0]  tx_kchar,
  output logic        frame_busy,
  output logic [7:0]  frame_seq,
  output logic [2:0]  fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SOF   = 3'd1,
    S_DATA  = 3'd2,
    S_FLUSH = 3'd3,
    S_EOF   = 3'd4
  } state_t;

  state_t      state;
  logic [15:0] timer;
  logic [16:0] issued;
  logic [15:0] byte_cnt;
  logic [7:0]  xor_sum;
  logic [2:0]  pack_cnt;
  logic [31:0] pack_word;
  logic [1:0]  rd_pipe;     // [0] = read issued last cycle, [1] = two cycles ago
  logic        eof_loaded;

  logic        data_vld;
  logic [1:0]  inflight;
  logic        out_free;
  logic        below_max;

  assign fsm_state = state;

  // Reads whose data has not yet come back; they reserve packing lanes so
  // the pack register can never overflow.
  assign data_vld  = (FIFO_RD_LAT == 1) ? rd_pipe[0] : rd_pipe[1];
  assign inflight  = (FIFO_RD_LAT == 1) ? {1'b0, rd_pipe[0]}
                                        : ({1'b0, rd_pipe[0]} + {1'b0, rd_pipe[1]});
  assign out_free  = !tx_valid || tx_ready;
  assign below_max = (issued < 17'(MAX_FRAME_BYTES));

  // Combinational so a read is never issued against a stale empty flag.
  assign fifo_rd_en = !rd_rst && (state == S_DATA) && !fifo_rd_empty && below_max &&
                      (({1'b0, pack_cnt} + {2'b00, inflight}) < 4'd4);

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state      <= S_IDLE;
      timer      <= '0;
      issued     <= '0;
      byte_cnt   <= '0;
      xor_sum    <= '0;
      pack_cnt   <= '0;
      pack_word  <= '0;
      rd_pipe    <= '0;
      eof_loaded <= 1'b0;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      tx_kchar   <= '0;
      frame_busy <= 1'b0;
      frame_seq  <= '0;
    end else begin
      rd_pipe <= {rd_pipe[0], fifo_rd_en};
      if (tx_valid && tx_ready) tx_valid <= 1'b0;
      if (fifo_rd_en) issued <= issued + 17'd1;

      // Returning bytes only occur in DATA, and never while pack_cnt==4.
      if (data_vld) begin
        pack_word[8*pack_cnt[1:0] +: 8] <= fifo_rd_data;
        pack_cnt <= pack_cnt + 3'd1;
        byte_cnt <= byte_cnt + 16'd1;
        xor_sum  <= xor_sum ^ fifo_rd_data;
      end

      case (state)
        S_IDLE: begin
          if (enable && !fifo_rd_empty && fifo_almost_empty) timer <= timer + 16'd1;
          else                                              timer <= '0;
          if (enable && !fifo_rd_empty &&
              (!fifo_almost_empty || timer == 16'(IDLE_TIMEOUT - 1))) begin
            timer <= '0;
            state <= S_SOF;
          end
        end
        S_SOF: begin
          if (out_free) begin
            tx_data    <= {frame_seq, 16'h0000, 8'hFB};
            tx_kchar   <= 4'b0001;
            tx_valid   <= 1'b1;
            byte_cnt   <= '0;
            xor_sum    <= '0;
            pack_cnt   <= '0;
            pack_word  <= '0;
            issued     <= '0;
            frame_busy <= 1'b1;
            state      <= S_DATA;
          end
        end
        S_DATA: begin
          if (pack_cnt == 3'd4 && out_free) begin
            tx_data   <= pack_word;
            tx_kchar  <= 4'b0000;
            tx_valid  <= 1'b1;
            pack_cnt  <= '0;
            pack_word <= '0;
          end
          if (inflight == 2'd0 && (!below_max || fifo_rd_empty)) state <= S_FLUSH;
        end
        S_FLUSH: begin
          // Upper lanes of a partial word are already zero from the last clear.
          if (pack_cnt == 3'd0) begin
            state <= S_EOF;
          end else if (out_free) begin
            tx_data   <= pack_word;
            tx_kchar  <= 4'b0000;
            tx_valid  <= 1'b1;
            pack_cnt  <= '0;
            pack_word <= '0;
            state     <= S_EOF;
          end
        end
        S_EOF: begin
          if (!eof_loaded) begin
            if (out_free) begin
              tx_data    <= {byte_cnt, xor_sum, 8'hFD};
              tx_kchar   <= 4'b0001;
              tx_valid   <= 1'b1;
              eof_loaded <= 1'b1;
            end
          end else if (tx_valid && tx_ready) begin
            frame_seq  <= frame_seq + 8'd1;
            frame_busy <= 1'b0;
            eof_loaded <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ad_buf_frame_ctrl.sv
// tb_ad_buf_frame_ctrl
//   Directed bench for ad_buf_frame_ctrl. A behavioural FIFO feeds the main
//   instance (default parameters); a second instance with an 8-byte frame
//   limit is fed by a byte-per-cycle source. Expected words are queued when
//   stimulus is issued and popped by monitors on each accepted output word.
module tb_ad_buf_frame_ctrl;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SOF  = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rd_rst = 1'b1;
  logic        enable = 1'b0;
  logic        fifo_rd_en;
  logic [7:0]  fifo_rd_data = 8'h00;
  logic        fifo_rd_empty = 1'b1;
  logic        fifo_almost_empty = 1'b1;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [31:0] tx_data;
  logic [3:0]  tx_kchar;
  logic        frame_busy;
  logic [7:0]  frame_seq;
  logic [2:0]  fsm_state;

  ad_buf_frame_ctrl dut (
    .rd_clk(clk), .rd_rst(rd_rst), .enable(enable),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_empty(fifo_rd_empty), .fifo_almost_empty(fifo_almost_empty),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_kchar(tx_kchar),
    .frame_busy(frame_busy), .frame_seq(frame_seq), .fsm_state(fsm_state)
  );

  // Second instance: 8-byte frames, continuous supply.
  logic        m8_rst = 1'b1;
  logic        m8_enable = 1'b1;
  logic        m8_rd_en;
  logic [7:0]  m8_rd_data = 8'h00;
  logic        m8_empty = 1'b1;
  logic        m8_ae = 1'b1;
  logic        m8_valid;
  logic        m8_ready = 1'b1;
  logic [31:0] m8_data;
  logic [3:0]  m8_kchar;
  logic        m8_busy;
  logic [7:0]  m8_seq;
  logic [2:0]  m8_state;

  ad_buf_frame_ctrl #(.MAX_FRAME_BYTES(8)) dut8 (
    .rd_clk(clk), .rd_rst(m8_rst), .enable(m8_enable),
    .fifo_rd_en(m8_rd_en), .fifo_rd_data(m8_rd_data),
    .fifo_rd_empty(m8_empty), .fifo_almost_empty(m8_ae),
    .tx_valid(m8_valid), .tx_ready(m8_ready), .tx_data(m8_data), .tx_kchar(m8_kchar),
    .frame_busy(m8_busy), .frame_seq(m8_seq), .fsm_state(m8_state)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- FIFO model (main instance) ----------------
  logic [7:0] fifo_q[$];
  logic [7:0] push_q[$];
  logic       ae_force = 1'b0;
  logic       fifo_flush = 1'b0;
  logic [7:0] pop_b;

  always @(posedge clk) begin
    if (fifo_flush) begin
      fifo_q.delete();
      push_q.delete();
    end else begin
      if (fifo_rd_en) begin
        checks++;
        if (fifo_q.size() == 0) begin
          errors++;
          $display("FAIL read_while_empty got rd_en=1 with 0 entries, want no read");
        end else begin
          pop_b = fifo_q.pop_front();
          fifo_rd_data <= pop_b;
        end
      end
      while (push_q.size() > 0) fifo_q.push_back(push_q.pop_front());
    end
    fifo_rd_empty     <= (fifo_q.size() == 0);
    fifo_almost_empty <= (fifo_q.size() <= 4) || ae_force;
  end

  // ---------------- tx_ready driver ----------------
  logic rdy_rand = 1'b0;
  always @(posedge clk) begin
    #1;
    tx_ready = rdy_rand ? ($urandom_range(0, 99) < 30) : 1'b1;
  end

  // ---------------- scoreboard / monitor (main instance) ----------------
  logic [35:0] exp_q[$];
  logic        mon_en = 1'b1;
  logic        hold = 1'b0;
  logic [35:0] hold_w;
  logic [35:0] mon_w;

  always @(negedge clk) begin
    if (rd_rst) begin
      hold = 1'b0;
    end else begin
      if (hold && mon_en) begin
        checks++;
        if (!tx_valid || {tx_kchar, tx_data} !== hold_w) begin
          errors++;
          $display("FAIL hold_stable got v=%0b %h want v=1 %h", tx_valid, {tx_kchar, tx_data}, hold_w);
        end
      end
      if (tx_valid && tx_ready && mon_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word got %h want none", {tx_kchar, tx_data});
        end else begin
          mon_w = exp_q.pop_front();
          if ({tx_kchar, tx_data} !== mon_w) begin
            errors++;
            $display("FAIL tx_word got %h want %h", {tx_kchar, tx_data}, mon_w);
          end
        end
      end
      hold   = tx_valid && !tx_ready;
      hold_w = {tx_kchar, tx_data};
    end
  end

  // ---------------- 8-byte instance: source and monitor ----------------
  int         m8_cnt = 0;
  int         m8_left = 32;
  logic [7:0] m8_val = 8'h00;
  logic [35:0] exp8_q[$];
  logic [35:0] m8_w;

  always @(posedge clk) begin
    if (m8_rd_en) begin
      checks++;
      if (m8_cnt == 0) begin
        errors++;
        $display("FAIL m8_read_while_empty got rd_en=1 with 0 entries, want no read");
      end else begin
        m8_rd_data <= m8_val;
        m8_val = m8_val + 8'd1;
        m8_cnt--;
      end
    end
    if (!m8_rst && m8_left > 0) begin
      m8_cnt++;
      m8_left--;
    end
    m8_empty <= (m8_cnt == 0);
    m8_ae    <= (m8_cnt <= 4);
  end

  always @(negedge clk) begin
    if (!m8_rst && m8_valid && m8_ready) begin
      checks++;
      if (exp8_q.size() == 0) begin
        errors++;
        $display("FAIL m8_unexpected_word got %h want none", {m8_kchar, m8_data});
      end else begin
        m8_w = exp8_q.pop_front();
        if ({m8_kchar, m8_data} !== m8_w) begin
          errors++;
          $display("FAIL m8_word got %h want %h", {m8_kchar, m8_data}, m8_w);
        end
      end
    end
  end

  // ---------------- driver / helper tasks ----------------
  logic [7:0] frame_bytes[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // Expected words for one frame made of frame_bytes.
  task automatic exp_frame(input logic [7:0] seq);
    logic [7:0]  x;
    logic [31:0] w;
    int n;
    n = frame_bytes.size();
    x = 8'h00;
    w = 32'h0;
    exp_q.push_back({4'b0001, seq, 16'h0000, 8'hFB});
    for (int i = 0; i < n; i++) begin
      x = x ^ frame_bytes[i];
      w[8*(i%4) +: 8] = frame_bytes[i];
      if ((i % 4) == 3 || i == n - 1) begin
        exp_q.push_back({4'b0000, w});
        w = 32'h0;
      end
    end
    exp_q.push_back({4'b0001, 16'(n), x, 8'hFD});
  endtask

  task automatic push_frame_bytes();
    foreach (frame_bytes[i]) push_q.push_back(frame_bytes[i]);
  endtask

  task automatic wait_state(input logic [2:0] s, input int maxc, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(negedge clk);
      if (fsm_state == s) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s timeout got state %0d want %0d", name, fsm_state, s);
    end
  endtask

  task automatic drain(input int maxc, input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < maxc && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !tx_valid && fsm_state == ST_IDLE) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s drain timeout got %0d words outstanding want 0", name, exp_q.size());
    end
  endtask

  // ---------------- main sequence ----------------
  int viol;
  int n_cyc;

  initial begin
    // expected frames for the 8-byte instance: bytes 0..31 in 4 frames
    for (int f = 0; f < 4; f++) begin
      logic [7:0] x;
      logic [7:0] b;
      x = 8'h00;
      exp8_q.push_back({4'b0001, 8'(f), 16'h0000, 8'hFB});
      for (int k = 0; k < 8; k++) begin
        b = 8'(8*f + k);
        x = x ^ b;
      end
      b = 8'(8*f);
      exp8_q.push_back({4'b0000, b + 8'd3, b + 8'd2, b + 8'd1, b});
      exp8_q.push_back({4'b0000, b + 8'd7, b + 8'd6, b + 8'd5, b + 8'd4});
      exp8_q.push_back({4'b0001, 16'd8, x, 8'hFD});
    end

    repeat (3) @(negedge clk);
    chk("rst_rd_en", {31'b0, fifo_rd_en}, 32'd0);
    chk("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    chk("rst_busy", {31'b0, frame_busy}, 32'd0);
    chk("rst_seq", {24'b0, frame_seq}, 32'd0);
    chk("rst_tx_data", tx_data, 32'd0);
    chk("rst_kchar", {28'b0, tx_kchar}, 32'd0);
    chk("rst_state", {29'b0, fsm_state}, 32'd0);
    rd_rst = 1'b0;
    m8_rst = 1'b0;

    // T1: 256 bytes 0x00..0xFF, full frame
    frame_bytes.delete();
    for (int i = 0; i < 256; i++) frame_bytes.push_back(8'(i));
    exp_frame(8'd0);
    @(negedge clk);
    push_frame_bytes();
    enable = 1'b1;
    drain(2000, "t1");
    chk("t1_seq", {24'b0, frame_seq}, 32'd1);
    chk("t1_busy", {31'b0, frame_busy}, 32'd0);

    // T2: 6 bytes with almost_empty held high -> timeout-started short frame
    @(negedge clk);
    ae_force = 1'b1;
    for (int i = 0; i < 6; i++) push_q.push_back(8'h11 + 8'(i));
    exp_q.push_back(36'h1_010000FB);
    exp_q.push_back(36'h0_14131211);
    exp_q.push_back(36'h0_00001615);
    exp_q.push_back(36'h1_000607FD);
    @(posedge clk);
    n_cyc = 0;
    for (int i = 1; i <= 200 && n_cyc == 0; i++) begin
      @(posedge clk);
      #1;
      if (fsm_state == ST_SOF) n_cyc = i;
    end
    chk("t2_timeout_cycles", n_cyc, 32'd64);
    drain(200, "t2");
    ae_force = 1'b0;
    chk("t2_seq", {24'b0, frame_seq}, 32'd2);

    // T3: 256-byte frame under 30% tx_ready
    frame_bytes.delete();
    for (int i = 0; i < 256; i++) frame_bytes.push_back(8'((i * 37 + 5) & 255));
    exp_frame(8'd2);
    @(negedge clk);
    rdy_rand = 1'b1;
    push_frame_bytes();
    drain(8000, "t3");
    rdy_rand = 1'b0;
    chk("t3_seq", {24'b0, frame_seq}, 32'd3);

    // T4: reset pulsed mid-DATA, then a clean frame
    mon_en = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 100; i++) push_q.push_back(8'(i));
    wait_state(ST_DATA, 50, "t4_reach_data");
    repeat (10) @(negedge clk);
    rd_rst = 1'b1;
    fifo_flush = 1'b1;
    @(negedge clk);
    rd_rst = 1'b0;
    fifo_flush = 1'b0;
    chk("t4_rd_en", {31'b0, fifo_rd_en}, 32'd0);
    chk("t4_tx_valid", {31'b0, tx_valid}, 32'd0);
    chk("t4_seq", {24'b0, frame_seq}, 32'd0);
    chk("t4_state", {29'b0, fsm_state}, 32'd0);
    chk("t4_busy", {31'b0, frame_busy}, 32'd0);
    exp_q.delete();
    mon_en = 1'b1;
    frame_bytes.delete();
    for (int i = 0; i < 8; i++) frame_bytes.push_back(8'hA0 + 8'(i));
    exp_frame(8'd0);
    push_frame_bytes();
    drain(300, "t4");
    chk("t4_seq_after", {24'b0, frame_seq}, 32'd1);

    // T5: enable low with a full FIFO, then enable dropped mid-frame
    enable = 1'b0;
    frame_bytes.delete();
    for (int i = 0; i < 256; i++) frame_bytes.push_back(8'(i) ^ 8'h5A);
    push_frame_bytes();
    for (int i = 0; i < 8; i++) push_q.push_back(8'hEE);
    viol = 0;
    repeat (1000) begin
      @(negedge clk);
      if (fifo_rd_en || tx_valid) viol++;
    end
    chk("t5_disabled_quiet", viol, 32'd0);
    exp_frame(8'd1);
    enable = 1'b1;
    wait_state(ST_DATA, 50, "t5_reach_data");
    enable = 1'b0;
    drain(2000, "t5");
    viol = 0;
    repeat (200) begin
      @(negedge clk);
      if (fifo_rd_en || tx_valid || fsm_state != ST_IDLE) viol++;
    end
    chk("t5_idle_after", viol, 32'd0);
    chk("t5_seq", {24'b0, frame_seq}, 32'd2);

    // 8-byte instance results
    chk("m8_words_left", exp8_q.size(), 32'd0);
    chk("m8_seq", {24'b0, m8_seq}, 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
